// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down counter with a programmable step, an inclusive upper
// limit, wrap or saturate behaviour at the bounds, a synchronous load, a
// count enable and boundary flags. It is a drop-in generalisation of the
// fixed 8-bit up/down counter. Typical uses are event, timer and address
// counting where that counter is too narrow or too rigid.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   STEP_W     width of the step input (1..WIDTH)
//   RESET_VAL  count value after reset (must be <= the limit in use)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, highest priority
//   enable    in   advance the count by one step on this edge
//   reverse   in   0 = count up, 1 = count down
//   load      in   synchronous load strobe (beats enable)
//   load_val  in   value to load, clamped to limit
//   step      in   increment/decrement magnitude; 0 holds the count
//   limit     in   inclusive upper bound of the legal range [0, limit]
//   saturate  in   0 = wrap at the bounds, 1 = clamp at the bounds
//   count     out  registered counter value
//   wrap      out  registered one-cycle pulse: the last update wrapped or
//                  pulled an out-of-range count back into range
//   at_max    out  combinational, count == limit
//   at_zero   out  combinational, count == 0
// ---------------------------------------------------------------------------
module updown_counter_param #(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              reverse,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              saturate,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              at_max,
  output logic              at_zero
);

  // One extra bit so that count + step and limit + 1 never overflow.
  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [EW-1:0]    w_cnt_x;
  logic [EW-1:0]    w_step_x;
  logic [EW-1:0]    w_lim_x;
  logic [EW-1:0]    w_lim_p1;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    w_diff;
  logic [EW-1:0]    w_up_wrap;
  logic [EW-1:0]    w_dn_wrap;
  logic             w_out_of_range;
  logic             w_step_zero;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;

  assign w_cnt_x   = {1'b0, r_count};
  assign w_step_x  = {{(EW-STEP_W){1'b0}}, step};
  assign w_lim_x   = {1'b0, limit};
  assign w_lim_p1  = w_lim_x + EW'(1);

  assign w_sum     = w_cnt_x + w_step_x;
  assign w_diff    = w_cnt_x - w_step_x;

  // Wrapped results. Only consulted when the plain sum/diff leaves the range.
  // A step larger than the whole range (limit + 1) can still land outside
  // [0, limit] after one wrap; those cases fall back to the bound below.
  // For the down case a negative result underflows to a value far above
  // limit in EW bits, so the same "> limit" test catches it.
  assign w_up_wrap = w_sum - w_lim_p1;
  assign w_dn_wrap = w_cnt_x + w_lim_p1 - w_step_x;

  // limit may be lowered below the current count at any time.
  assign w_out_of_range = (w_cnt_x > w_lim_x);
  assign w_step_zero    = (step == '0);
  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;

    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (!enable || w_step_zero) begin
      w_count_nxt = r_count;
    end else if (w_out_of_range) begin
      w_count_nxt = reverse ? limit : '0;
      w_wrap_nxt  = 1'b1;
    end else if (!reverse) begin
      if (w_sum <= w_lim_x) begin
        w_count_nxt = w_sum[WIDTH-1:0];
      end else if (saturate) begin
        w_count_nxt = limit;
      end else begin
        w_count_nxt = (w_up_wrap <= w_lim_x) ? w_up_wrap[WIDTH-1:0] : '0;
        w_wrap_nxt  = 1'b1;
      end
    end else begin
      if (w_cnt_x >= w_step_x) begin
        w_count_nxt = w_diff[WIDTH-1:0];
      end else if (saturate) begin
        w_count_nxt = '0;
      end else begin
        w_count_nxt = (w_dn_wrap <= w_lim_x) ? w_dn_wrap[WIDTH-1:0] : limit;
        w_wrap_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RESET_VAL;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign at_max  = (r_count == limit);
  assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int RV = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          reverse;
  logic          load;
  logic [W-1:0]  load_val;
  logic [SW-1:0] step;
  logic [W-1:0]  limit;
  logic          saturate;
  logic [W-1:0]  count;
  logic          wrap;
  logic          at_max;
  logic          at_zero;

  updown_counter_param #(
    .WIDTH    (W),
    .STEP_W   (SW),
    .RESET_VAL(W'(RV))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .reverse (reverse),
    .load    (load),
    .load_val(load_val),
    .step    (step),
    .limit   (limit),
    .saturate(saturate),
    .count   (count),
    .wrap    (wrap),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit w;
    bit mx;
    bit z;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   m_cnt   = 0;
  bit   m_wrap  = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model written directly from the behavioural description,
  // using signed integers rather than a widened bit vector.
  task automatic model_step();
    int c, s, r, lim, stp;
    bit w;
    c   = m_cnt;
    w   = 1'b0;
    lim = int'(limit);
    stp = int'(step);
    if (reset) begin
      c = RV;
    end else if (load) begin
      c = (int'(load_val) > lim) ? lim : int'(load_val);
    end else if (!enable || stp == 0) begin
      c = m_cnt;
    end else if (c > lim) begin
      c = reverse ? lim : 0;
      w = 1'b1;
    end else if (!reverse) begin
      s = c + stp;
      if (s <= lim) c = s;
      else if (saturate) c = lim;
      else begin
        r = s - (lim + 1);
        c = (r <= lim) ? r : 0;
        w = 1'b1;
      end
    end else begin
      if (c >= stp) c = c - stp;
      else if (saturate) c = 0;
      else begin
        r = c + lim + 1 - stp;
        c = (r >= 0 && r <= lim) ? r : lim;
        w = 1'b1;
      end
    end
    m_cnt  = c;
    m_wrap = w;
  endtask

  // Push the expectation for the current inputs, clock once, then pop and
  // compare one cycle later, sampling 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    model_step();
    e.c  = m_cnt;
    e.w  = m_wrap;
    e.mx = (m_cnt == int'(limit));
    e.z  = (m_cnt == 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_count", int'(count), e.c);
      chk("sb_wrap", int'(wrap), int'(e.w));
      chk("sb_at_max", int'(at_max), int'(e.mx));
      chk("sb_at_zero", int'(at_zero), int'(e.z));
    end
  endtask

  task automatic set_mode(input int lim, input int stp, input bit sat, input bit rev);
    limit    = W'(lim);
    step     = SW'(stp);
    saturate = sat;
    reverse  = rev;
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = W'(v);
    tick();
    load     = 1'b0;
  endtask

  int seq_up[4]  = '{3, 6, 9, 2};
  int seq_wu[4]  = '{0, 0, 0, 1};

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    reverse  = 1'b0;
    load     = 1'b0;
    load_val = '0;
    step     = SW'(1);
    limit    = W'(255);
    saturate = 1'b0;

    // Reset state
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_zero", int'(at_zero), 1);
    reset = 1'b0;

    // Plain modulo-256 behaviour
    set_mode(255, 1, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("up255_count", int'(count), 255);
    chk("up255_max", int'(at_max), 1);
    tick();
    chk("rollover_count", int'(count), 0);
    chk("rollover_wrap", int'(wrap), 1);
    tick();
    chk("wrap_one_cycle", int'(wrap), 0);

    do_load(255);
    reverse = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("down100_count", int'(count), 155);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("reset_hold_count", int'(count), 0);
    chk("reset_hold_wrap", int'(wrap), 0);
    chk("reset_hold_zero", int'(at_zero), 1);
    reset = 1'b0;

    // limit 9, step 3, wrap mode
    set_mode(9, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lim9_up", int'(count), seq_up[i]);
      chk("lim9_up_wrap", int'(wrap), seq_wu[i]);
    end
    reverse = 1'b1;
    tick();
    chk("lim9_dn_a", int'(count), 9);
    chk("lim9_dn_a_wrap", int'(wrap), 1);
    tick();
    chk("lim9_dn_b", int'(count), 6);
    chk("lim9_dn_b_wrap", int'(wrap), 0);

    // Saturate mode
    enable = 1'b0;
    set_mode(9, 3, 1'b1, 1'b0);
    do_load(6);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_up", int'(count), 9);
      chk("sat_up_wrap", int'(wrap), 0);
    end
    enable = 1'b0;
    do_load(2);
    enable  = 1'b1;
    reverse = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sat_dn", int'(count), 0);
      chk("sat_dn_wrap", int'(wrap), 0);
    end

    // Load clamping and priority
    enable = 1'b0;
    set_mode(50, 1, 1'b0, 1'b0);
    do_load(200);
    chk("load_clamp", int'(count), 50);
    enable = 1'b1;
    do_load(20);
    chk("load_beats_en", int'(count), 20);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_count", int'(count), 20);

    // Out-of-range correction after lowering limit
    set_mode(255, 1, 1'b0, 1'b0);
    do_load(8);
    limit  = W'(5);
    enable = 1'b1;
    tick();
    chk("oor_up_count", int'(count), 0);
    chk("oor_up_wrap", int'(wrap), 1);
    enable = 1'b0;
    limit  = W'(255);
    do_load(8);
    limit   = W'(5);
    reverse = 1'b1;
    enable  = 1'b1;
    tick();
    chk("oor_dn_count", int'(count), 5);
    chk("oor_dn_wrap", int'(wrap), 1);
    step = '0;
    tick();
    chk("step0_count", int'(count), 5);
    chk("step0_wrap", int'(wrap), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 11) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      reverse  = $urandom_range(0, 1) == 1;
      saturate = ($urandom_range(0, 2) == 0);
      step     = SW'($urandom_range(0, 15));
      load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        limit = ($urandom_range(0, 3) == 0) ? W'(255) : W'($urandom_range(0, 40));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
